// File: rtl/dram_bus_arbiter.sv
// Round-robin arbiter sharing one DRAM bus target; one transaction in flight, posted writes.
// Optional read watchdog enabled by defining ARB_WATCHDOG_EN.
module dram_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SRC_W          = 3,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_is_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_payload,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_is_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_payload,
    output logic [SRC_W-1:0]            mem_source,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_data,
    input  logic [SRC_W-1:0]            mem_resp_source,
    output logic                        err_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    grant, src_q;
    logic [NUM_REQ-1:0]  grant_oh, src_oh;
    logic                any_req, resp_hit, timeout_hit;
    logic                is_write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   payload_q;
    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    int                  idx;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        any_req  = 1'b0;
        grant    = '0;
        grant_oh = '0;
        rr_ptr_d = rr_ptr_q;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!any_req && req_valid[idx]) begin
                any_req       = 1'b1;
                grant         = SRC_W'(idx);
                grant_oh[idx] = 1'b1;
                rr_ptr_d      = SRC_W'((idx + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        src_oh = '0;
        for (int i = 0; i < NUM_REQ; i++)
            src_oh[i] = (src_q == SRC_W'(i));
    end

    assign resp_hit = (state_q == WAIT_RESP) && mem_resp_valid && (mem_resp_source == src_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (any_req) state_d = ISSUE;
            ISSUE:     if (mem_req_ready) state_d = is_write_q ? IDLE : WAIT_RESP;
            WAIT_RESP: if (resp_hit || timeout_hit) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state_q == IDLE) ? grant_oh : '0;
        mem_req_valid = (state_q == ISSUE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= '0;
            src_q        <= '0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            payload_q    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= '0;
            if (state_q == IDLE && any_req) begin
                rr_ptr_q   <= rr_ptr_d;
                src_q      <= grant;
                is_write_q <= req_is_write[grant_idx()];
                addr_q     <= req_addr[grant_idx()*ADDR_W +: ADDR_W];
                payload_q  <= req_payload[grant_idx()*DATA_W +: DATA_W];
            end
            if (resp_hit) begin
                resp_valid_q <= src_oh;
                resp_data_q  <= mem_resp_data;
            end else if (timeout_hit) begin
                resp_valid_q <= src_oh;
                resp_data_q  <= '0;
            end
        end
    end

    function automatic int grant_idx();
        return int'(grant);
    endfunction

`ifdef ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign timeout_hit = (state_q == WAIT_RESP) && !resp_hit && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside WAIT_RESP, so each read starts a fresh window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == WAIT_RESP) ? cnt_q + 1'b1 : '0;
            err_q <= err_q | timeout_hit;
        end
    end
    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign mem_is_write = is_write_q;
    assign mem_addr    = addr_q;
    assign mem_payload = payload_q;
    assign mem_source  = src_q;
endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Directed bench for dram_bus_arbiter: write, read, fairness, backpressure, wrong source, reset, watchdog.
module tb_dram_bus_arbiter;
    localparam int NR = 4, SW = 3, AW = 64, DW = 64;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NR-1:0]      req_valid = '0, req_ready, req_is_write = '0, resp_valid;
    logic [NR*AW-1:0]   req_addr = '0;
    logic [NR*DW-1:0]   req_payload = '0;
    logic [DW-1:0]      resp_data, mem_payload, mem_resp_data = '0;
    logic               mem_req_valid, mem_req_ready = 1'b1, mem_is_write;
    logic [AW-1:0]      mem_addr;
    logic [SW-1:0]      mem_source, mem_resp_source = '0;
    logic               mem_resp_valid = 1'b0, err_timeout;

    int n_chk = 0, n_fail = 0;

    dram_bus_arbiter #(.NUM_REQ(NR), .SRC_W(SW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_payload(req_payload),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_is_write(mem_is_write),
        .mem_addr(mem_addr), .mem_payload(mem_payload), .mem_source(mem_source),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_source(mem_resp_source), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [63:0] a, input logic [63:0] d);
        req_is_write[i]      = wr;
        req_addr[i*AW +: AW] = a;
        req_payload[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        // reset state
        #3;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
        check("rst_err_timeout", 64'(err_timeout), 64'h0);
        reset_n = 1'b1;
        tick();

        // single posted write from requester 0
        set_req(0, 1'b1, 64'h100, 64'h1122334455667788);
        req_valid = 4'b0001;
        #1;
        check("wr_req_ready", 64'(req_ready), 64'h1);
        check("wr_idle_mem_valid", 64'(mem_req_valid), 64'h0);
        tick();
        req_valid = '0;
        #1;
        check("wr_mem_valid", 64'(mem_req_valid), 64'h1);
        check("wr_mem_src", 64'(mem_source), 64'h0);
        check("wr_mem_addr", mem_addr, 64'h100);
        check("wr_mem_payload", mem_payload, 64'h1122334455667788);
        check("wr_mem_is_write", 64'(mem_is_write), 64'h1);
        tick();
        check("wr_done_mem_valid", 64'(mem_req_valid), 64'h0);
        check("wr_no_resp", 64'(resp_valid), 64'h0);

        // read from requester 2, DRAM answers five cycles after issue
        set_req(2, 1'b0, 64'h100, 64'h0);
        req_valid = 4'b0100;
        #1;
        check("rd_req_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        #1;
        check("rd_mem_src", 64'(mem_source), 64'h2);
        check("rd_mem_is_write", 64'(mem_is_write), 64'h0);
        tick();
        check("rd_wait_mem_valid", 64'(mem_req_valid), 64'h0);
        for (int c = 0; c < 4; c++) tick();
        mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFEF00D; mem_resp_source = 3'd2;
        #1;
        check("rd_resp_not_yet", 64'(resp_valid), 64'h0);
        tick();
        mem_resp_valid = 1'b0;
        check("rd_resp_valid", 64'(resp_valid), 64'h4);
        check("rd_resp_data", resp_data, 64'hCAFEF00D);
        tick();
        check("rd_resp_one_cycle", 64'(resp_valid), 64'h0);

        // fairness: all four requesters write continuously
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 64'h1000 + 64'(i), 64'hA0 + 64'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
            tick();
            check($sformatf("rr_src_%0d", k), 64'(mem_source), 64'(k % 4));
            check($sformatf("rr_addr_%0d", k), mem_addr, 64'h1000 + 64'(k % 4));
            tick();
        end
        req_valid = '0;

        // backpressure: ISSUE held for 10 cycles, rr_ptr now at 0 so pick req1 alone first
        mem_req_ready = 1'b0;
        set_req(1, 1'b1, 64'h200, 64'hDEAD);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_mem_valid", 64'(mem_req_valid), 64'h1);
            check("bp_addr", mem_addr, 64'h200);
            check("bp_payload", mem_payload, 64'hDEAD);
            check("bp_src", 64'(mem_source), 64'h1);
            check("bp_req_ready", 64'(req_ready), 64'h0);
            tick();
        end
        req_valid = '0;
        mem_req_ready = 1'b1;
        tick();
        check("bp_released", 64'(mem_req_valid), 64'h0);

        // response while IDLE is ignored
        mem_resp_valid = 1'b1; mem_resp_source = 3'd0; mem_resp_data = 64'h77;
        tick();
        mem_resp_valid = 1'b0;
        check("idle_resp_ignored", 64'(resp_valid), 64'h0);

        // wrong source dropped: rr_ptr=2, only req3 valid
        set_req(3, 1'b0, 64'h300, 64'h0);
        req_valid = 4'b1000;
        #1;
        check("ws_req_ready", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_source = 3'd1; mem_resp_data = 64'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 1'b1, 64'h400, 64'h1);
        #1;
        check("ws_dropped", 64'(resp_valid), 64'h0);
        check("ws_still_wait", 64'(req_ready), 64'h0);
        tick();
        tick();
        mem_resp_valid = 1'b1; mem_resp_source = 3'd3; mem_resp_data = 64'h5555;
        #1;
        check("ws_resp_first", 64'(req_ready), 64'h0);
        tick();
        mem_resp_valid = 1'b0;
        check("ws_resp_valid", 64'(resp_valid), 64'h8);
        check("ws_resp_data", resp_data, 64'h5555);
        check("ws_next_idle", 64'(req_ready), 64'h1);
        req_valid = '0;
        #1;
        check("ws_drop_free", 64'(req_ready), 64'h0);
        tick();

        // reset in WAIT_RESP; rr_ptr would be 2 after granting req1
        set_req(1, 1'b0, 64'h500, 64'h0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("ar_mem_valid", 64'(mem_req_valid), 64'h0);
        check("ar_resp_valid", 64'(resp_valid), 64'h0);
        check("ar_resp_data", resp_data, 64'h0);
        check("ar_req_ready", 64'(req_ready), 64'h0);
        reset_n = 1'b1;
        set_req(3, 1'b0, 64'h600, 64'h0);
        req_valid = 4'b1010;
        #1;
        check("ar_rr_from_0", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        check("ar_no_resp", 64'(resp_valid), 64'h0);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("wd_quiet", 64'(resp_valid), 64'h0);
        end
        tick();
`ifdef ARB_WATCHDOG_EN
        check("wd_resp_valid", 64'(resp_valid), 64'h2);
        check("wd_resp_data", resp_data, 64'h0);
        check("wd_err", 64'(err_timeout), 64'h1);
        tick();
        check("wd_err_sticky", 64'(err_timeout), 64'h1);
        check("wd_pulse_one", 64'(resp_valid), 64'h0);
`else
        check("nowd_resp_valid", 64'(resp_valid), 64'h0);
        check("nowd_err", 64'(err_timeout), 64'h0);
        req_valid = 4'b0001;
        #1;
        check("nowd_still_wait", 64'(req_ready), 64'h0);
        req_valid = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
